// File: rtl/dual_update_if.sv
// Handshake and vector bus of the ADMM dual-update stage.
// prim_res exists only when DUAL_RESIDUAL_EN is defined.
interface dual_update_if #(
    parameter int unsigned STATE_DIM   = 12,
    parameter int unsigned CONTROL_DIM = 4,
    parameter int unsigned W           = 16
);
    logic                              start;
    logic [STATE_DIM-1:0][W-1:0]       x_k;
    logic [STATE_DIM-1:0][W-1:0]       v_k;
    logic [STATE_DIM-1:0][W-1:0]       y_k;
    logic [CONTROL_DIM-1:0][W-1:0]     u_k;
    logic [CONTROL_DIM-1:0][W-1:0]     z_k;
    logic [CONTROL_DIM-1:0][W-1:0]     g_k;
    logic [STATE_DIM-1:0][W-1:0]       y_next;
    logic [CONTROL_DIM-1:0][W-1:0]     g_next;
    logic                              busy;
    logic                              done;
`ifdef DUAL_RESIDUAL_EN
    logic [W-1:0]                      prim_res;
`endif

    modport master (
        output start, x_k, v_k, y_k, u_k, z_k, g_k,
        input  y_next, g_next, busy, done
`ifdef DUAL_RESIDUAL_EN
        , input prim_res
`endif
    );

    modport slave (
        input  start, x_k, v_k, y_k, u_k, z_k, g_k,
        output y_next, g_next, busy, done
`ifdef DUAL_RESIDUAL_EN
        , output prim_res
`endif
    );
endinterface

// File: rtl/dual_update.sv
// ADMM dual-variable update: y' = sat(y + x - v), g' = sat(g + u - z), one element per cycle.
// Optional max primal residual output guarded by DUAL_RESIDUAL_EN.
module dual_update #(
    parameter int unsigned STATE_DIM   = 12,
    parameter int unsigned CONTROL_DIM = 4,
    parameter int unsigned W           = 16
) (
    input  logic          clk,
    input  logic          reset,
    dual_update_if.slave  bus
);

    if (STATE_DIM == 0 || CONTROL_DIM == 0) begin : g_bad_dim
        $error("dual_update: STATE_DIM and CONTROL_DIM must be non-zero");
    end

    localparam int unsigned MaxDim = (STATE_DIM > CONTROL_DIM) ? STATE_DIM : CONTROL_DIM;
    localparam int unsigned IdxW   = (MaxDim > 1) ? $clog2(MaxDim) : 1;

    localparam logic [IdxW-1:0] LastSt = IdxW'(STATE_DIM - 1);
    localparam logic [IdxW-1:0] LastCt = IdxW'(CONTROL_DIM - 1);

    localparam logic [W-1:0] SatMax = {1'b0, {(W-1){1'b1}}};
    localparam logic [W-1:0] SatMin = {1'b1, {(W-1){1'b0}}};

    localparam logic [1:0] StIdle = 2'd0;
    localparam logic [1:0] StSt   = 2'd1;
    localparam logic [1:0] StCt   = 2'd2;
    localparam logic [1:0] StDone = 2'd3;

    logic [1:0]                      state_q, state_d;
    logic [IdxW-1:0]                 idx_q, idx_d;
    logic                            load;

    logic [STATE_DIM-1:0][W-1:0]     x_q, v_q, y_q;
    logic [CONTROL_DIM-1:0][W-1:0]   u_q, z_q, g_q;
    logic [STATE_DIM-1:0][W-1:0]     y_next_q, y_next_d;
    logic [CONTROL_DIM-1:0][W-1:0]   g_next_q, g_next_d;

    logic [W-1:0]                    op_a, op_b, op_dual;
    logic [W:0]                      diff;
    logic [W+1:0]                    sum;
    logic [W-1:0]                    sat_res;
    logic                            wr_en;

    // Sequencing: one element per edge through ST then CT.
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        load    = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (bus.start) begin
                    load    = 1'b1;
                    state_d = StSt;
                    idx_d   = '0;
                end
            end
            StSt: begin
                if (idx_q == LastSt) begin
                    state_d = StCt;
                    idx_d   = '0;
                end else begin
                    idx_d = idx_q + IdxW'(1);
                end
            end
            StCt: begin
                if (idx_q == LastCt) begin
                    state_d = StDone;
                    idx_d   = '0;
                end else begin
                    idx_d = idx_q + IdxW'(1);
                end
            end
            StDone: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
                idx_d   = '0;
            end
        endcase
    end

    assign wr_en = (state_q == StSt) || (state_q == StCt);

    // Shared datapath: pick the element addressed by idx from the snapshot.
    always_comb begin
        op_a    = '0;
        op_b    = '0;
        op_dual = '0;
        for (int i = 0; i < int'(STATE_DIM); i++) begin
            if (state_q == StSt && idx_q == IdxW'(i)) begin
                op_a    = x_q[i];
                op_b    = v_q[i];
                op_dual = y_q[i];
            end
        end
        for (int j = 0; j < int'(CONTROL_DIM); j++) begin
            if (state_q == StCt && idx_q == IdxW'(j)) begin
                op_a    = u_q[j];
                op_b    = z_q[j];
                op_dual = g_q[j];
            end
        end
    end

    always_comb begin
        diff = {op_a[W-1], op_a} - {op_b[W-1], op_b};
        sum  = {{2{op_dual[W-1]}}, op_dual} + {diff[W], diff};
        // In range exactly when the three top bits agree.
        if (sum[W+1:W-1] == 3'b000 || sum[W+1:W-1] == 3'b111) begin
            sat_res = sum[W-1:0];
        end else if (sum[W+1]) begin
            sat_res = SatMin;
        end else begin
            sat_res = SatMax;
        end
    end

    always_comb begin
        y_next_d = y_next_q;
        g_next_d = g_next_q;
        for (int i = 0; i < int'(STATE_DIM); i++) begin
            if (state_q == StSt && idx_q == IdxW'(i)) begin
                y_next_d[i] = sat_res;
            end
        end
        for (int j = 0; j < int'(CONTROL_DIM); j++) begin
            if (state_q == StCt && idx_q == IdxW'(j)) begin
                g_next_d[j] = sat_res;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= StIdle;
            idx_q    <= '0;
            x_q      <= '0;
            v_q      <= '0;
            y_q      <= '0;
            u_q      <= '0;
            z_q      <= '0;
            g_q      <= '0;
            y_next_q <= '0;
            g_next_q <= '0;
        end else begin
            state_q  <= state_d;
            idx_q    <= idx_d;
            y_next_q <= y_next_d;
            g_next_q <= g_next_d;
            if (load) begin
                x_q <= bus.x_k;
                v_q <= bus.v_k;
                y_q <= bus.y_k;
                u_q <= bus.u_k;
                z_q <= bus.z_k;
                g_q <= bus.g_k;
            end
        end
    end

`ifdef DUAL_RESIDUAL_EN
    logic [W:0]   mag;
    logic [W-1:0] mag_sat;
    logic [W-1:0] prim_res_q, prim_res_d;

    always_comb begin
        mag        = diff[W] ? (~diff + (W+1)'(1)) : diff;
        mag_sat    = (mag[W:W-1] != 2'b00) ? SatMax : mag[W-1:0];
        prim_res_d = prim_res_q;
        if (load) begin
            prim_res_d = '0;
        end else if (wr_en && (mag_sat > prim_res_q)) begin
            prim_res_d = mag_sat;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            prim_res_q <= '0;
        end else begin
            prim_res_q <= prim_res_d;
        end
    end

    assign bus.prim_res = prim_res_q;
`endif

    assign bus.y_next = y_next_q;
    assign bus.g_next = g_next_q;
    assign bus.busy   = wr_en;
    assign bus.done   = (state_q == StDone);

endmodule
